// File: rtl/cpu_mem_pkg.sv
// Shared types and bounds for the CPU-to-SRAM arbitration path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_mem_pkg;

  // Arbiter/tracker state: IDLE has nothing outstanding, WAIT counts read latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Which channel owns the outstanding access.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 4;
  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_LIM_DEF = 4;

  // Latency counter only ever holds 0..RD_LAT_MAX-1.
  localparam int CNT_W = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks the single outstanding SRAM access and times its response pulse.
// Latency: resp_fire asserts exactly RD_LAT cycles after the accepting cycle.
// Backpressure: none; the response cannot be stalled.
//
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   accept        an access is issued to the SRAM this cycle
//   accept_owner  channel that owns the access being issued
//   busy          an access is outstanding (state WAIT)
//   resp_fire     response cycle of the outstanding access
//   resp_owner    owner of the outstanding access
module mem_resp_tracker
  import cpu_mem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   accept,
  input  owner_t accept_owner,
  output logic   busy,
  output logic   resp_fire,
  output owner_t resp_owner
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_INST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    resp_fire = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new accept overrides the return to IDLE, so a response cycle can
    // also issue the next access and keep one access per RD_LAT cycles.
    if (accept) begin
      state_d = WAIT;
      cnt_d   = '0;
      owner_d = accept_owner;
    end
  end

  assign busy       = (state_q == WAIT);
  assign resp_owner = owner_q;

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Merges the core's fetch and data channels onto one single-port synchronous SRAM.
// Latency: grant is combinational; the response comes RD_LAT cycles after accept.
// Backpressure: addr_ok withheld while an access is outstanding or the other channel wins.
//
// Ports:
//   clk, resetn                        clock and synchronous active-low reset
//   inst_req/addr -> inst_addr_ok      fetch request and its accept strobe
//   inst_data_ok, inst_rdata           fetch response pulse and data
//   data_req/wr/wstrb/addr/wdata       load/store request
//   data_addr_ok, data_data_ok/rdata   load/store accept strobe and response
//   mem_en/we/addr/wdata, mem_rdata    SRAM port
//   busy                               an access is outstanding
module cpu_sram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int              SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIM);

  logic          trk_busy;
  logic          resp_fire;
  owner_t        resp_owner;
  logic          window;
  logic          grant_data;
  logic          grant_inst;
  logic          resp_ok;
  logic [SW-1:0] starve_q;

  // Accept window: idle, or the outstanding response is delivered this cycle.
  // Everything is qualified by resetn so all outputs read 0 while in reset.
  assign window     = resetn && (!trk_busy || resp_fire);
  assign grant_data = window && data_req && !(inst_req && (starve_q == STARVE_MAX));
  assign grant_inst = window && inst_req && !grant_data;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_en   = 1'b1;
      mem_addr = data_addr;
      if (data_wr) begin
        mem_we    = data_wstrb;
        mem_wdata = data_wdata;
      end
    end else if (grant_inst) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end
  end

  // Starvation guard: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!inst_req || grant_inst) begin
      starve_q <= '0;
    end else if (grant_data && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  mem_resp_tracker #(
    .RD_LAT(RD_LAT)
  ) u_tracker (
    .clk         (clk),
    .resetn      (resetn),
    .accept      (grant_data || grant_inst),
    .accept_owner(grant_data ? OWN_DATA : OWN_INST),
    .busy        (trk_busy),
    .resp_fire   (resp_fire),
    .resp_owner  (resp_owner)
  );

  // Memory read data passes straight through to the owner only.
  assign resp_ok      = resetn && resp_fire;
  assign inst_data_ok = resp_ok && (resp_owner == OWN_INST);
  assign data_data_ok = resp_ok && (resp_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;
  assign busy         = resetn && trk_busy;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench: two arbiter instances (RD_LAT=1 and RD_LAT=3) share stimulus;
// sel3 picks which instance the current test observes.
module tb_cpu_sram_arbiter;

  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  logic        inst_addr_ok_1, inst_data_ok_1, data_addr_ok_1, data_data_ok_1, mem_en_1, busy_1;
  logic [31:0] inst_rdata_1, data_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic [3:0]  mem_we_1;
  logic        inst_addr_ok_3, inst_data_ok_3, data_addr_ok_3, data_data_ok_3, mem_en_3, busy_3;
  logic [31:0] inst_rdata_3, data_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [3:0]  mem_we_3;

  int checks = 0;
  int failures = 0;

  cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_LIM(LIM)) dut1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok_1),
    .inst_data_ok(inst_data_ok_1), .inst_rdata(inst_rdata_1),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok_1), .data_data_ok(data_data_ok_1),
    .data_rdata(data_rdata_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
  );

  cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_LIM(LIM)) dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok_3),
    .inst_data_ok(inst_data_ok_3), .inst_rdata(inst_rdata_3),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok_3), .data_data_ok(data_data_ok_3),
    .data_rdata(data_rdata_3), .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  // SRAM contents are a fixed function of the address.
  function automatic logic [31:0] fdat(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0c0c;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // SRAM models: read data valid RD_LAT cycles after a read enable, noise otherwise.
  logic [3:0]  ren_1 = '0;
  logic [3:0]  ren_3 = '0;
  logic [31:0] ra_1 [4];
  logic [31:0] ra_3 [4];
  logic [31:0] noise = 32'h0;
  always @(posedge clk) begin
    ren_1   <= {ren_1[2:0], mem_en_1 && (mem_we_1 == 4'b0)};
    ren_3   <= {ren_3[2:0], mem_en_3 && (mem_we_3 == 4'b0)};
    ra_1[0] <= mem_addr_1;
    ra_3[0] <= mem_addr_3;
    for (int i = 1; i < 4; i++) begin
      ra_1[i] <= ra_1[i-1];
      ra_3[i] <= ra_3[i-1];
    end
    noise <= $urandom;
  end
  assign mem_rdata_1 = ren_1[0] ? fdat(ra_1[0]) : noise;
  assign mem_rdata_3 = ren_3[2] ? fdat(ra_3[2]) : noise;

  // Observed instance.
  logic        sel3;
  logic        v_iaok, v_idok, v_daok, v_ddok, v_en, v_busy;
  logic [31:0] v_irdata, v_drdata, v_addr, v_wdata;
  logic [3:0]  v_we;
  logic [137:0] v_all;
  assign v_iaok   = sel3 ? inst_addr_ok_3 : inst_addr_ok_1;
  assign v_idok   = sel3 ? inst_data_ok_3 : inst_data_ok_1;
  assign v_daok   = sel3 ? data_addr_ok_3 : data_addr_ok_1;
  assign v_ddok   = sel3 ? data_data_ok_3 : data_data_ok_1;
  assign v_en     = sel3 ? mem_en_3 : mem_en_1;
  assign v_busy   = sel3 ? busy_3 : busy_1;
  assign v_irdata = sel3 ? inst_rdata_3 : inst_rdata_1;
  assign v_drdata = sel3 ? data_rdata_3 : data_rdata_1;
  assign v_addr   = sel3 ? mem_addr_3 : mem_addr_1;
  assign v_wdata  = sel3 ? mem_wdata_3 : mem_wdata_1;
  assign v_we     = sel3 ? mem_we_3 : mem_we_1;
  assign v_all    = {v_iaok, v_idok, v_irdata, v_daok, v_ddok, v_drdata,
                     v_en, v_we, v_addr, v_wdata, v_busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
  endtask

  task automatic test_reset(input bit s);
    sel3 = s;
    resetn = 0;
    inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'hf;
    inst_addr = 32'h40; data_addr = 32'h44; data_wdata = 32'h1234;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (v_all !== '0) begin
      failures++; $display("FAIL reset_outputs lat3=%0d got=%h want=0", s, v_all);
    end
    clear_inputs();
    resetn = 1;
    tick();
    @(negedge clk);
    checks++;
    if (v_all !== '0) begin
      failures++; $display("FAIL idle_outputs lat3=%0d got=%h want=0", s, v_all);
    end
  endtask

  task automatic test_single_fetch();
    sel3 = 0; do_reset(); tick();
    inst_req = 1; inst_addr = 32'h1c00_0000;
    @(negedge clk);
    checks++;
    if ({v_iaok, v_daok, v_en, v_we, v_addr, v_wdata, v_busy} !== {3'b101, 4'h0, 32'h1c00_0000, 32'h0, 1'b0}) begin
      failures++; $display("FAIL fetch_accept got iaok=%b en=%b addr=%h we=%h busy=%b", v_iaok, v_en, v_addr, v_we, v_busy);
    end
    tick(); inst_req = 0;
    @(negedge clk);
    checks++;
    if ({v_idok, v_irdata, v_ddok, v_busy} !== {1'b1, 32'h0280_0c0c, 1'b0, 1'b1}) begin
      failures++; $display("FAIL fetch_resp got idok=%b rdata=%h busy=%b want 1 02800c0c 1", v_idok, v_irdata, v_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v_all !== '0) begin
      failures++; $display("FAIL fetch_after got=%h want=0", v_all);
    end
  endtask

  task automatic test_conflict();
    sel3 = 0; do_reset(); tick();
    inst_req = 1; inst_addr = 32'h1c00_0010;
    data_req = 1; data_wr = 0; data_addr = 32'h80;
    @(negedge clk);
    checks++;
    if ({v_daok, v_iaok, v_addr, v_we} !== {2'b10, 32'h80, 4'h0}) begin
      failures++; $display("FAIL conflict_c0 got daok=%b iaok=%b addr=%h want 1 0 80", v_daok, v_iaok, v_addr);
    end
    tick(); data_req = 0;
    @(negedge clk);
    checks++;
    if ({v_iaok, v_daok, v_ddok, v_drdata, v_addr} !== {3'b101, fdat(32'h80), 32'h1c00_0010}) begin
      failures++; $display("FAIL conflict_c1 got iaok=%b ddok=%b rdata=%h addr=%h", v_iaok, v_ddok, v_drdata, v_addr);
    end
    tick(); inst_req = 0;
    @(negedge clk);
    checks++;
    if ({v_idok, v_irdata, v_ddok, v_drdata} !== {1'b1, fdat(32'h1c00_0010), 1'b0, 32'h0}) begin
      failures++; $display("FAIL conflict_c2 got idok=%b irdata=%h ddok=%b", v_idok, v_irdata, v_ddok);
    end
  endtask

  task automatic test_store();
    logic [3:0] strb [2];
    strb[0] = 4'b0011; strb[1] = 4'b0000;
    sel3 = 0; do_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      data_req = 1; data_wr = 1; data_wstrb = strb[k];
      data_addr = 32'h100; data_wdata = 32'hdead_beef;
      @(negedge clk);
      checks++;
      if ({v_daok, v_en, v_we, v_addr, v_wdata} !== {2'b11, strb[k], 32'h100, 32'hdead_beef}) begin
        failures++; $display("FAIL store_accept%0d got daok=%b we=%b addr=%h wdata=%h want we=%b", k, v_daok, v_we, v_addr, v_wdata, strb[k]);
      end
      tick(); clear_inputs();
      @(negedge clk);
      checks++;
      if ({v_ddok, v_idok} !== 2'b10) begin
        failures++; $display("FAIL store_resp%0d got ddok=%b idok=%b want 1 0", k, v_ddok, v_idok);
      end
    end
  endtask

  task automatic test_starve();
    sel3 = 0; do_reset(); tick();
    inst_req = 1; data_req = 1; data_wr = 0;
    for (int c = 0; c < 15; c++) begin
      inst_addr = 32'h1c00_0000 + 32'(c * 4);
      data_addr = 32'h400 + 32'(c * 4);
      @(negedge clk);
      checks++;
      if ({v_iaok, v_daok} !== ((c % 5 == 4) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL starve_c%0d got iaok=%b daok=%b", c, v_iaok, v_daok);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_b2b_lat3();
    int acc = 0;
    sel3 = 1; do_reset(); tick();
    for (int c = 0; c <= 10; c++) begin
      data_req = (acc < 3); data_wr = 0; data_addr = 32'h200 + 32'(acc * 4);
      @(negedge clk);
      checks++;
      if ({v_daok, v_ddok, v_busy} !== {(c == 0 || c == 3 || c == 6), (c == 3 || c == 6 || c == 9), (c >= 1 && c <= 9)}) begin
        failures++; $display("FAIL b2b_c%0d got daok=%b ddok=%b busy=%b", c, v_daok, v_ddok, v_busy);
      end
      if (c == 3 || c == 6 || c == 9) begin
        checks++;
        if (v_drdata !== fdat(32'h200 + 32'((c / 3 - 1) * 4))) begin
          failures++; $display("FAIL b2b_rdata_c%0d got=%h want=%h", c, v_drdata, fdat(32'h200 + 32'((c / 3 - 1) * 4)));
        end
      end
      if (v_daok) acc++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    sel3 = 1; do_reset(); tick();
    data_req = 1; data_wr = 0; data_addr = 32'h300;
    @(negedge clk);
    checks++;
    if (v_daok !== 1'b1) begin
      failures++; $display("FAIL rstmid_accept got daok=%b want 1", v_daok);
    end
    tick(); data_req = 0; resetn = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (v_all !== '0) begin
        failures++; $display("FAIL rstmid_in_reset%0d got=%h want=0", c, v_all);
      end
      tick();
    end
    resetn = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({v_ddok, v_idok, v_busy} !== 3'b000) begin
        failures++; $display("FAIL rstmid_quiet%0d got ddok=%b idok=%b busy=%b", c, v_ddok, v_idok, v_busy);
      end
      tick();
    end
    inst_req = 1; inst_addr = 32'h1c00_0040;
    @(negedge clk);
    checks++;
    if (v_iaok !== 1'b1) begin
      failures++; $display("FAIL rstmid_fetch_accept got iaok=%b want 1", v_iaok);
    end
    tick(); inst_req = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if ({v_idok, v_irdata} !== {(c == 3), (c == 3) ? fdat(32'h1c00_0040) : 32'h0}) begin
        failures++; $display("FAIL rstmid_fetch_c%0d got idok=%b rdata=%h", c, v_idok, v_irdata);
      end
      tick();
    end
  endtask

  // Randomized traffic against a cycle-level model of the arbitration rules.
  task automatic test_random(input bit s, input int ncyc);
    int lat, starve, due;
    bit outst, own_data, own_store, ip, dp, win, fire, gd, gi;
    logic [31:0] exp_d;
    lat = s ? 3 : 1;
    starve = 0; due = 0; outst = 0; own_data = 0; own_store = 0; ip = 0; dp = 0; exp_d = 0;
    sel3 = s; do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; inst_addr = $urandom & 32'h0000_fffc;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; data_addr = $urandom & 32'h0000_fffc; data_wr = $urandom_range(0, 1);
        data_wstrb = $urandom_range(0, 15); data_wdata = $urandom;
      end
      inst_req = ip; data_req = dp;
      @(negedge clk);
      win  = !outst || (cyc == due);
      fire = outst && (cyc == due);
      gd   = win && dp && !(ip && starve == LIM);
      gi   = win && ip && !gd;
      checks++;
      if ({v_iaok, v_daok, v_en, v_busy, v_idok, v_ddok} !== {gi, gd, gi || gd, outst, fire && !own_data, fire && own_data}) begin
        failures++;
        $display("FAIL rand_ctl lat=%0d cyc=%0d got=%b want=%b", lat, cyc,
                 {v_iaok, v_daok, v_en, v_busy, v_idok, v_ddok}, {gi, gd, gi || gd, outst, fire && !own_data, fire && own_data});
      end
      checks++;
      if (v_irdata !== ((fire && !own_data) ? exp_d : 32'h0)) begin
        failures++; $display("FAIL rand_irdata lat=%0d cyc=%0d got=%h", lat, cyc, v_irdata);
      end
      if (!(fire && own_store)) begin
        checks++;
        if (v_drdata !== ((fire && own_data) ? exp_d : 32'h0)) begin
          failures++; $display("FAIL rand_drdata lat=%0d cyc=%0d got=%h", lat, cyc, v_drdata);
        end
      end
      if (gd) begin
        checks++;
        if ({v_addr, v_we} !== {data_addr, data_wr ? data_wstrb : 4'h0} || (data_wr && v_wdata !== data_wdata)) begin
          failures++; $display("FAIL rand_data_port lat=%0d cyc=%0d addr=%h we=%b wdata=%h", lat, cyc, v_addr, v_we, v_wdata);
        end
      end
      if (gi) begin
        checks++;
        if ({v_addr, v_we, v_wdata} !== {inst_addr, 4'h0, 32'h0}) begin
          failures++; $display("FAIL rand_inst_port lat=%0d cyc=%0d addr=%h we=%b wdata=%h", lat, cyc, v_addr, v_we, v_wdata);
        end
      end
      if (fire) outst = 0;
      if (gi || gd) begin
        outst = 1; due = cyc + lat; own_data = gd; own_store = gd && data_wr;
        exp_d = fdat(gd ? data_addr : inst_addr);
      end
      if (!ip || gi) starve = 0;
      else if (gd && starve < LIM) starve++;
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    clear_inputs();
  endtask

  initial begin
    sel3 = 0;
    clear_inputs();
    resetn = 0;
    test_reset(0);
    test_reset(1);
    test_single_fetch();
    test_conflict();
    test_store();
    test_starve();
    test_b2b_lat3();
    test_reset_mid();
    test_random(0, 400);
    test_random(1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Sits directly downstream of the five-stage CPU core.
- Takes the core's separate instruction-fetch and data-access request channels and merges them onto one single-port synchronous SRAM.
- Uses a req/addr_ok/data_ok handshake per channel and tracks one outstanding transaction at a time.
- Data requests have priority over fetch, with a starvation guard so fetch always makes forward progress.

Parameters:
- ADDR_W, 32, address width of both channels and the memory port
- DATA_W, 32, data width; wstrb width is DATA_W/8
- RD_LAT, 1, fixed memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4
- STARVE_LIM, 4, consecutive data grants allowed while inst_req is pending before fetch is forced

Ports:
- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  fetch request valid
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid (1-cycle pulse)
- inst_rdata  out  DATA_W  fetch data, valid when inst_data_ok
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  DATA_W/8  byte enables for stores
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid (1-cycle pulse; also returned for stores)
- data_rdata  out  DATA_W  load data, valid when data_data_ok
- mem_en  out  1  SRAM enable
- mem_we  out  DATA_W/8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after mem_en
- busy  out  1  a transaction is outstanding

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State IDLE; latency counter, starve counter and owner register cleared.
  - All outputs 0 while in reset, and in IDLE with no request.
- States:
  - IDLE: no outstanding access.
  - WAIT: access issued, counting RD_LAT.
- Accept window (cycle t):
  - Open when state==IDLE, or when state==WAIT and the response is delivered this cycle (cnt==RD_LAT-1).
  - Back-to-back throughput is one access per RD_LAT cycles.
- Grant in the accept window:
  - If data_req and !(inst_req && starve_cnt==STARVE_LIM): grant data.
  - Else if inst_req: grant inst.
  - Grant is combinational in cycle t: the matching addr_ok=1, mem_en=1, mem_addr/mem_we/mem_wdata driven from the granted channel.
  - Fetch grant: mem_we=0, mem_wdata=0.
  - Load: mem_we=0.
  - Store: mem_we=data_wstrb. data_wstrb=0 is a legal no-op write and still returns data_ok.
- Only one addr_ok is high per cycle. A non-granted request sees addr_ok=0; the requester holds req, addr and wdata stable until addr_ok.
- Response:
  - Exactly RD_LAT cycles after accept, assert the owner's data_ok for one cycle.
  - rdata = mem_rdata, passed combinationally; the non-owner's rdata is 0.
  - The requester cannot back-pressure responses.
- State transitions:
  - Accept moves to WAIT with cnt=0.
  - In WAIT, cnt increments each cycle.
  - At cnt==RD_LAT-1 the response fires; the state returns to IDLE, or stays in WAIT with cnt=0 if a new accept happens in the same cycle.
- Starve counter:
  - Increments (saturating at STARVE_LIM) on each data grant while inst_req=1.
  - Clears on any inst grant, or whenever inst_req=0.
- busy = (state==WAIT).
- Reset mid-transaction: the pending response is discarded; no data_ok after reset; memory output is ignored.
- Simultaneous inst_req and data_req with starve_cnt<STARVE_LIM: data wins; inst waits.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the state enum (IDLE, WAIT),
  - the owner enum (OWN_INST, OWN_DATA),
  - the default STARVE_LIM and RD_LAT bounds.
- One sub-module, mem_resp_tracker:
  - contains the latency counter, owner register and response-pulse generation;
  - outputs resp_fire and resp_owner.
- Arbitration and memory muxing stay in the top of the block.

Test Plan:
- Single fetch, RD_LAT=1: inst_req=1, inst_addr=0x1c000000 in cycle 0, mem_rdata=0x02800c0c in cycle 1 -> inst_addr_ok=1, mem_en=1, mem_addr=0x1c000000 in cycle 0; inst_data_ok=1, inst_rdata=0x02800c0c in cycle 1; busy=1 only in cycle 1.
- Conflict: inst_req and data_req (load, addr 0x80) both raised in cycle 0 -> data_addr_ok in cycle 0; inst_addr_ok in cycle 1 (the response cycle); inst_data_ok in cycle 2.
- Store: data_wr=1, data_wstrb=4'b0011, data_addr=0x100, data_wdata=0xdeadbeef -> mem_we=4'b0011, mem_wdata=0xdeadbeef in cycle 0; data_data_ok=1 in cycle 1.
- Starvation guard, STARVE_LIM=4: inst_req and data_req held high continuously -> 4 data grants, then 1 inst grant, then data again; pattern repeats.
- RD_LAT=3 back-to-back loads -> accepts in cycles 0, 3 and 6; data_data_ok in cycles 3, 6 and 9; no accept in cycles 1–2.
- Reset mid-access: resetn=0 in cycle 1 of an RD_LAT=3 load -> no data_ok afterwards; all outputs 0 during reset; a fetch issued after reset release completes normally.
